shift_engine: RTL
=================

SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 2..64.
REQ-002 Parameter STEP, default 1, maximum bit positions shifted per clock; legal range 1..WIDTH.
REQ-003 Derived constant SW = clog2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i  input  WIDTH  load operand.
REQ-007 s  input  SW  shift amount, sampled with start.
REQ-008 c  input  3  opcode: 000 hold, 001 SHL, 010 SHR, 011 LOAD, 100 SAR, 101 ROL, 110 ROR, 111 reserved.
REQ-009 start  input  1  command request; accepted only in IDLE.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 o  output  WIDTH  result register.
REQ-013 co  output  1  last bit shifted out or rotated around.
REQ-014 z  output  1  combinational flag, o == 0.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1: capture c and s; an opcode of SHL, SHR, SAR, ROL or ROR with s != 0 -> SHIFT with rem = s.
REQ-017 IDLE with start=1 and opcode hold, reserved, or any shift with s = 0: -> DONE, o unchanged; co cleared to 0 for a shift opcode, otherwise unchanged.
REQ-018 IDLE with start=1 and opcode LOAD: o <= i on the same edge; -> DONE; co unchanged.
REQ-019 Each SHIFT edge: o shifted by k = min(rem, STEP); rem <= rem - k; rem reaching 0 -> DONE.
REQ-020 Latency for a shift with s != 0: start edge plus ceil(s/STEP) SHIFT edges; done high in the cycle after the last chunk.
REQ-021 Latency for zero-length operations: done high in the cycle immediately after the start edge.
REQ-022 DONE SHALL last exactly one cycle and then -> IDLE; a start during DONE is ignored.
REQ-023 A start during SHIFT SHALL be ignored; the captured c and s SHALL NOT change mid-operation.
REQ-024 SHL and SHR zero-fill; SAR replicates o[WIDTH-1]; ROL and ROR wrap bits around; all results truncated to WIDTH bits.
REQ-025 co after each chunk: SHL -> pre-chunk bit o[WIDTH-k]; SHR/SAR -> pre-chunk bit o[k-1]; ROL -> new o[0]; ROR -> new o[WIDTH-1].
REQ-026 Input i SHALL be ignored except on a LOAD accept; o SHALL hold its value in IDLE.

Reset
REQ-027 rst=1 SHALL immediately force state=IDLE, o=0, co=0, rem=0, busy=0 and done=0, regardless of clk.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; z=1 after reset.

Structure
REQ-029 The shared package SHALL hold the opcode constants and the state enumeration (IDLE, SHIFT, DONE).
REQ-030 A combinational sub-module shift_chunk(WIDTH, STEP) SHALL compute the shifted data and carry from data, opcode and k; shift_engine holds the FSM and registers.

Verification (WIDTH=8 unless stated)
REQ-031 STEP=1: LOAD 0xA5, then SHL s=3 -> busy for 3 cycles, done pulse, o=0x28, co=1, z=0.
REQ-032 STEP=1: LOAD 0x81, then SAR s=7 -> o=0xFF, co=0, done 7 cycles after the accept edge.
REQ-033 STEP=4: LOAD 0x96, then ROL s=5 -> 2 SHIFT cycles, o=0xD2, co=0.
REQ-034 SHR s=0 on o=0x3C -> done the next cycle, o=0x3C, co=0; opcode 111 -> done, o and co unchanged.
REQ-035 Start a SHL s=4 with STEP=1 and pulse start with LOAD 0xFF during SHIFT -> the second start is ignored, o=0x3C<<4 truncated to 8 bits = 0xC0.
REQ-036 Assert rst asynchronously in the 2nd SHIFT cycle -> o=0, co=0, busy=0, no done pulse, z=1; the next command runs normally.

Source files
------------

// File: rtl/shift_engine_pkg.sv
// Shared opcode constants, FSM state encoding and opcode classification for the shift engine.
package shift_engine_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHL  = 3'b001;
    localparam logic [2:0] OP_SHR  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_SAR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ROR  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR};
    endfunction

endpackage

// File: rtl/shift_chunk.sv
// One chunk of a multi-cycle shift: moves data by k (1..STEP) positions and reports the carry bit.
module shift_chunk
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] q,
    output logic             co
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    int               kk;
    logic [WIDTH-1:0] shl, shr, sar, rol, ror;
    logic [WIDTH-1:0] msk_hi, msk_lo;

    assign kk  = int'(k);
    assign shl = d << kk;
    assign shr = d >> kk;
    assign sar = $signed(d) >>> kk;
    assign rol = (d << kk) | (d >> (WIDTH - kk));
    assign ror = (d >> kk) | (d << (WIDTH - kk));

    // Single-bit masks select the last bit to leave the word on either side.
    assign msk_hi = ONE << (WIDTH - kk);
    assign msk_lo = ONE << (kk - 1);

    always_comb begin
        q  = d;
        co = 1'b0;
        case (op)
            OP_SHL: begin q = shl; co = |(d & msk_hi); end
            OP_SHR: begin q = shr; co = |(d & msk_lo); end
            OP_SAR: begin q = sar; co = |(d & msk_lo); end
            OP_ROL: begin q = rol; co = rol[0];        end
            OP_ROR: begin q = ror; co = ror[WIDTH-1];  end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shift/rotate engine: IDLE -> SHIFT (STEP bits per clock) -> DONE, one command at a time.
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic [SW-1:0]    s,
    input  logic [2:0]       c,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             co,
    output logic             z
);

    localparam int KW = $clog2(STEP + 1);

    state_t           state, nxt;
    logic [2:0]       op_q;
    logic [SW-1:0]    rem;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] q_chunk;
    logic             co_chunk;

    // Chunk size never exceeds what is left, so the final chunk lands exactly on s.
    assign k = (int'(rem) < STEP) ? KW'(rem) : KW'(STEP);

    shift_chunk #(.WIDTH(WIDTH), .STEP(STEP)) u_chunk (
        .d  (o),
        .op (op_q),
        .k  (k),
        .q  (q_chunk),
        .co (co_chunk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = (is_shift(c) && s != '0) ? SHIFT : DONE;
            SHIFT:   if (int'(rem) <= STEP) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o    <= '0;
            co   <= 1'b0;
            rem  <= '0;
            op_q <= OP_HOLD;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q <= c;
                    rem  <= s;
                    if (c == OP_LOAD)
                        o <= i;
                    else if (is_shift(c) && s == '0)
                        co <= 1'b0;
                end
                SHIFT: begin
                    o   <= q_chunk;
                    co  <= co_chunk;
                    rem <= rem - SW'(k);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign z    = (o == '0);

endmodule
